// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_PORTS requesters; 1-cycle arbitration then registered issue, read data returned 1 cycle after i_mem_ack.
// Backpressure: i_mem_busy holds the issued command and the granted requester's busy; reads stall while the outstanding-read ID FIFO is full.
module memory_arbiter #(
   parameter int NUM_PORTS       = 4,
   parameter int READ_FIFO_DEPTH = 4
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   input  logic [NUM_PORTS-1:0]      i_req_request,
   input  logic [NUM_PORTS-1:0]      i_req_write,
   output logic [NUM_PORTS-1:0]      o_req_busy,
   output logic [NUM_PORTS-1:0]      o_req_ack,
   input  logic [4*NUM_PORTS-1:0]    i_req_bank,
   input  logic [24*NUM_PORTS-1:0]   i_req_address,
   input  logic [32*NUM_PORTS-1:0]   i_req_data,
   output logic [31:0]               o_req_data,
   output logic                      o_mem_request,
   output logic                      o_mem_write,
   input  logic                      i_mem_busy,
   input  logic                      i_mem_ack,
   output logic [3:0]                o_mem_bank,
   output logic [23:0]               o_mem_address,
   output logic [31:0]               o_mem_data,
   input  logic [31:0]               i_mem_data,
   output logic                      o_error
);

   localparam int IW = $clog2(NUM_PORTS);
   localparam int FW = $clog2(READ_FIFO_DEPTH);
   localparam int CW = FW + 1;

   typedef enum logic {S_IDLE, S_ISSUE} state_t;

   state_t              r_state;
   logic [IW-1:0]       r_grant;
   logic [IW-1:0]       r_last;
   logic [IW-1:0]       r_fifo [READ_FIFO_DEPTH];
   logic [FW-1:0]       r_wr_ptr;
   logic [FW-1:0]       r_rd_ptr;
   logic [CW-1:0]       r_count;

   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic [NUM_PORTS-1:0] w_elig;
   logic                w_any;
   logic [IW-1:0]       w_pick;
   int                  w_idx;
   logic                w_accept;
   logic                w_push;
   logic                w_pop;

   assign w_fifo_full  = (r_count == CW'(READ_FIFO_DEPTH));
   assign w_fifo_empty = (r_count == '0);
   // Writes are always eligible; reads only while a return slot is free.
   assign w_elig       = i_req_request & (i_req_write | {NUM_PORTS{!w_fifo_full}});
   assign w_accept     = (r_state == S_ISSUE) && o_mem_request && !i_mem_busy;
   assign w_push       = w_accept && !o_mem_write;
   assign w_pop        = i_mem_ack && !w_fifo_empty;

   always_comb begin
      w_any  = 1'b0;
      w_pick = '0;
      w_idx  = 0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         w_idx = (int'(r_last) + k) % NUM_PORTS;
         if (!w_any && w_elig[w_idx]) begin
            w_any  = 1'b1;
            w_pick = IW'(w_idx);
         end
      end
   end

   always_comb begin
      o_req_busy = '1;
      if (r_state == S_ISSUE && !i_mem_busy)
         o_req_busy[r_grant] = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state       <= S_IDLE;
         r_grant       <= '0;
         r_last        <= IW'(NUM_PORTS - 1);
         o_mem_request <= 1'b0;
         o_mem_write   <= 1'b0;
         o_mem_bank    <= '0;
         o_mem_address <= '0;
         o_mem_data    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_grant       <= w_pick;
                  r_last        <= w_pick;
                  o_mem_request <= 1'b1;
                  o_mem_write   <= i_req_write[w_pick];
                  o_mem_bank    <= i_req_bank[int'(w_pick)*4 +: 4];
                  o_mem_address <= i_req_address[int'(w_pick)*24 +: 24];
                  o_mem_data    <= i_req_data[int'(w_pick)*32 +: 32];
                  r_state       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // Grant is committed: completes even if the requester drops its request.
               if (w_accept) begin
                  o_mem_request <= 1'b0;
                  r_state       <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_fifo[r_wr_ptr] <= r_grant;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_req_ack  <= '0;
         o_req_data <= '0;
         o_error    <= 1'b0;
      end else begin
         o_req_ack <= '0;
         if (w_pop) begin
            o_req_ack[r_fifo[r_rd_ptr]] <= 1'b1;
            o_req_data                  <= i_mem_data;
         end
         if (i_mem_ack && w_fifo_empty)
            o_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_memory_arbiter;
   localparam int N = 4;
   localparam int D = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_request = '0, req_write = '0;
   logic [N-1:0]    req_busy, req_ack;
   logic [4*N-1:0]  req_bank = '0;
   logic [24*N-1:0] req_address = '0;
   logic [32*N-1:0] req_wdata = '0;
   logic [31:0]     req_rdata;
   logic            mem_request, mem_write, mem_busy = 1'b0, mem_ack = 1'b0, error;
   logic [3:0]      mem_bank;
   logic [23:0]     mem_address;
   logic [31:0]     mem_wdata, mem_rdata = '0;

   memory_arbiter #(.NUM_PORTS(N), .READ_FIFO_DEPTH(D)) dut (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_req_request(req_request), .i_req_write(req_write),
      .o_req_busy(req_busy), .o_req_ack(req_ack),
      .i_req_bank(req_bank), .i_req_address(req_address), .i_req_data(req_wdata),
      .o_req_data(req_rdata),
      .o_mem_request(mem_request), .o_mem_write(mem_write), .i_mem_busy(mem_busy),
      .i_mem_ack(mem_ack), .o_mem_bank(mem_bank), .o_mem_address(mem_address),
      .o_mem_data(mem_wdata), .i_mem_data(mem_rdata), .o_error(error)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: one outstanding command slot plus a queue of read owners.
   bit          m_issue;
   int          m_grant, m_last;
   logic        m_req, m_wr;
   logic [3:0]  m_bank;
   logic [23:0] m_addr;
   logic [31:0] m_data, m_rdata;
   logic [N-1:0] m_ack;
   logic        m_err;
   int          mq[$];

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_issue = 0; m_grant = 0; m_last = N - 1;
         m_req = 0; m_wr = 0; m_bank = 0; m_addr = 0; m_data = 0;
         m_rdata = 0; m_ack = 0; m_err = 0; mq.delete();
      end else begin
         automatic int  occ = mq.size();
         automatic bit  push = 0;
         automatic int  pick = -1;
         if (m_issue) begin
            if (!mem_busy) begin
               m_issue = 0; m_req = 0;
               push = !m_wr;
            end
         end else begin
            for (int k = 1; k <= N; k++) begin
               automatic int p = (m_last + k) % N;
               if (pick < 0 && req_request[p] && (req_write[p] || occ < D)) pick = p;
            end
            if (pick >= 0) begin
               m_issue = 1; m_grant = pick; m_last = pick; m_req = 1;
               m_wr = req_write[pick];
               m_bank = req_bank[4*pick +: 4];
               m_addr = req_address[24*pick +: 24];
               m_data = req_wdata[32*pick +: 32];
            end
         end
         m_ack = '0;
         if (mem_ack) begin
            if (occ > 0) begin
               m_ack[mq.pop_front()] = 1'b1;
               m_rdata = mem_rdata;
            end else m_err = 1;
         end
         if (push) mq.push_back(m_grant);
      end
   end

   // Monitor / memory responder bookkeeping at the active edge.
   int          cyc = 0, last_ack_cyc = -10;
   logic [N-1:0] acc_vec = '0;
   int          gport[$], gwr[$], gcyc[$], alog[$];
   logic [31:0] pend_data[$];
   int          pend_due[$];
   int          ack_delay = 0;
   bit          rd_fixed = 0;
   logic [31:0] rd_pat = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
      acc_vec = req_request & ~req_busy;
      if (rst_n && mem_request && !mem_busy) begin
         automatic int p = -1;
         for (int i = 0; i < N; i++) if (acc_vec[i]) p = i;
         gport.push_back(p); gwr.push_back(int'(mem_write)); gcyc.push_back(cyc);
         if (!mem_write) begin
            pend_data.push_back(rd_fixed ? rd_pat : $urandom);
            pend_due.push_back(cyc + ((ack_delay == 0) ? $urandom_range(1, 6) : ack_delay));
         end
      end
   end

   initial forever begin
      @(negedge clk);
      begin
         automatic logic [N-1:0] eb = '1;
         if (m_issue && !mem_busy) eb[m_grant] = 1'b0;
         chk("mem_request", mem_request, m_req);
         chk("mem_write", mem_write, m_wr);
         chk("mem_bank", mem_bank, m_bank);
         chk("mem_address", mem_address, m_addr);
         chk("mem_data", mem_wdata, m_data);
         chk("req_busy", req_busy, eb);
         chk("req_ack", req_ack, m_ack);
         chk("req_data", req_rdata, m_rdata);
         chk("error", error, m_err);
         for (int i = 0; i < N; i++) if (req_ack[i]) alog.push_back(i);
      end
   end

   // Stimulus driver, applied 1 time unit after each active edge.
   bit [N-1:0] p_act = '0, gen_en = '0;
   int         wr_mode[N];
   int         gen_pct = 100, busy_mode = 0;
   bit         hold_acks = 0, spur = 0;

   task automatic start_req(input int p, input bit wr, input logic [3:0] b,
                            input logic [23:0] a, input logic [31:0] d);
      p_act[p] = 1; req_request[p] = 1; req_write[p] = wr;
      req_bank[4*p +: 4] = b; req_address[24*p +: 24] = a; req_wdata[32*p +: 32] = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc_vec[i]) begin p_act[i] = 0; req_request[i] = 0; end
         if (!p_act[i] && gen_en[i] && $urandom_range(0, 99) < gen_pct)
            start_req(i, (wr_mode[i] == 2) ? 1'($urandom_range(0, 1)) : 1'(wr_mode[i]),
                      4'($urandom), 24'($urandom), $urandom);
      end
      acc_vec = '0;
      case (busy_mode)
         0: mem_busy = 0;
         1: mem_busy = ($urandom_range(0, 99) < 30);
         default: mem_busy = 1;
      endcase
      mem_ack = 0;
      if (spur) begin
         mem_ack = 1; mem_rdata = 32'h5555_AAAA; last_ack_cyc = cyc;
      end else if (!hold_acks && pend_due.size() > 0 && pend_due[0] <= cyc &&
                   (ack_delay != 0 || $urandom_range(0, 1) == 1)) begin
         mem_ack = 1; mem_rdata = pend_data.pop_front(); void'(pend_due.pop_front());
         last_ack_cyc = cyc;
      end
   endtask

   task automatic reset_dut();
      rst_n = 0;
      req_request = '0; req_write = '0; p_act = '0; gen_en = '0;
      mem_busy = 0; mem_ack = 0; busy_mode = 0; hold_acks = 0; spur = 0;
      pend_data.delete(); pend_due.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bit found;
      int nrd, nwr;
      reset_dut();
      @(negedge clk);
      chk("rst_mem_request", mem_request, 0);
      chk("rst_busy", req_busy, 4'hF);
      chk("rst_ack", req_ack, 0);
      chk("rst_error", error, 0);

      // Single read from port 2, memory acks 3 cycles after accept.
      ack_delay = 3; rd_fixed = 1; rd_pat = 32'hDEADBEEF;
      start_req(2, 0, 4'h1, 24'h000100, 32'h0);
      found = 0;
      for (int k = 0; k < 30 && !found; k++) begin
         tick(); @(negedge clk);
         if (req_ack != 0) found = 1;
      end
      chk("t1_ack_seen", found, 1);
      chk("t1_ack_vec", req_ack, 4'b0100);
      chk("t1_ack_data", req_rdata, 32'hDEADBEEF);
      chk("t1_latency", cyc, last_ack_cyc + 1);
      chk("t1_model_ack", m_ack, 4'b0100);
      rd_fixed = 0;

      // All ports writing continuously: strict rotation, one accept per 2 cycles.
      reset_dut();
      gport.delete(); gcyc.delete(); gwr.delete();
      for (int i = 0; i < N; i++) wr_mode[i] = 1;
      gen_en = '1; gen_pct = 100;
      for (int k = 0; k < 40 && gport.size() < 8; k++) tick();
      chk("t2_grants", gport.size() >= 8, 1);
      for (int k = 0; k < 8 && k < gport.size(); k++) begin
         chk("t2_order", gport[k], k % N);
         if (k > 0) chk("t2_spacing", gcyc[k] - gcyc[k-1], 2);
      end
      gen_en = '0;
      repeat (10) tick();

      // Memory busy during issue holds the command.
      reset_dut();
      busy_mode = 2;
      start_req(1, 1, 4'h7, 24'h0ABCDE, 32'h12345678);
      repeat (6) tick();
      @(negedge clk);
      chk("t3_req_held", mem_request, 1);
      chk("t3_busy1", req_busy[1], 1);
      chk("t3_addr", mem_address, 24'h0ABCDE);
      chk("t3_data", mem_wdata, 32'h12345678);
      busy_mode = 0;
      tick(); @(negedge clk);
      chk("t3_accept_vec", req_busy, 4'b1101);
      tick(); @(negedge clk);
      chk("t3_req_dropped", mem_request, 0);

      // Reads from ports 1,3 fill the ID FIFO; port 0 writes keep flowing.
      reset_dut();
      gport.delete(); gwr.delete(); gcyc.delete();
      ack_delay = 1; hold_acks = 1;
      wr_mode[0] = 1; wr_mode[1] = 0; wr_mode[3] = 0;
      gen_en = 4'b1011; gen_pct = 100;
      repeat (30) tick();
      nrd = 0; nwr = 0;
      foreach (gport[k]) begin
         if (gwr[k] == 0) nrd++;
         else if (gport[k] == 0) nwr++;
      end
      chk("t4_reads_capped", nrd, 4);
      chk("t4_writes_flow", nwr >= 5, 1);
      gen_en = '0;
      req_request[1] = 0; req_request[3] = 0; p_act[1] = 0; p_act[3] = 0;
      alog.delete();
      hold_acks = 0;
      repeat (40) tick();
      chk("t4_ack_count", alog.size(), 4);
      for (int k = 0; k < 4 && k < alog.size(); k++)
         chk("t4_ack_route", alog[k], (k % 2 == 0) ? 1 : 3);

      // Ack with nothing outstanding, then reset in the middle of an issue.
      spur = 1; tick(); spur = 0;
      tick(); @(negedge clk);
      chk("t5_error_set", error, 1);
      chk("t5_no_ack", req_ack, 0);
      repeat (3) tick();
      @(negedge clk);
      chk("t5_error_sticky", error, 1);
      busy_mode = 2;
      start_req(0, 1, 4'h3, 24'h000042, 32'hCAFEF00D);
      repeat (3) tick();
      @(negedge clk);
      chk("t5_in_issue", mem_request, 1);
      #1 rst_n = 0;
      #1;
      chk("t5_async_req", mem_request, 0);
      chk("t5_async_error", error, 0);
      reset_dut();

      // Random traffic.
      for (int i = 0; i < N; i++) wr_mode[i] = 2;
      ack_delay = 0; gen_en = '1; gen_pct = 40; busy_mode = 1;
      repeat (3000) tick();
      gen_en = '0; busy_mode = 0;
      repeat (100) tick();
      @(negedge clk);
      chk("rand_no_error", error, 0);
      chk("rand_drained", mq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
